// File: rtl/dct_sequencer.sv
// dct_sequencer
// Sequences a full 2-D DCT of one IMG_W x IMG_W image held in the coefficient
// buffer: row pass -> transpose -> column pass -> transpose. Each pass feeds
// 8-sample segments to the shared row multiplier and keeps at most MAX_OUT
// requests in flight. Results come back in issue order and are written back to
// the buffer. Each transpose swaps every off-diagonal pair, one pair per cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a transform (accepted only when idle)
//   busy, done, phase   status: busy while running, one-cycle done pulse,
//                       phase 0 IDLE / 1 ROW / 2 TR1 / 3 COL / 4 TR2
//   err                 sticky flag: multiplier result with nothing outstanding
//   mul_req/addr/ack    request handshake to the multiplier (req && ack = issue)
//   mul_vld             multiplier result ready (in issue order)
//   wr_en, wr_addr      buffer write-back of one 8-coefficient segment
//   sw_en, sw_addr_a/b  buffer word swap for the transposes
module dct_sequencer #(
  parameter int IMG_W   = 256,
  parameter int MAX_OUT = 2,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    phase,
  output logic          err,
  output logic          mul_req,
  output logic [AW-1:0] mul_addr,
  input  logic          mul_ack,
  input  logic          mul_vld,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          sw_en,
  output logic [AW-1:0] sw_addr_a,
  output logic [AW-1:0] sw_addr_b
);

  localparam int SEGS = IMG_W * IMG_W / 8;
  localparam int SW   = $clog2(SEGS + 1);
  localparam int LW   = $clog2(IMG_W);
  localparam int OW   = $clog2(MAX_OUT + 1);
  localparam int PW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [SW-1:0] SEGS_V = SW'(SEGS);
  localparam logic [OW-1:0] MAX_V  = OW'(MAX_OUT);
  localparam logic [LW-1:0] LAST_I = LW'(IMG_W - 2);
  localparam logic [LW-1:0] LAST_J = LW'(IMG_W - 1);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROW  = 3'd1,
    S_TR1  = 3'd2,
    S_COL  = 3'd3,
    S_TR2  = 3'd4
  } phase_t;

  phase_t state, state_nxt;

  logic [SW-1:0] seg;
  logic [OW-1:0] outstanding;
  logic [LW-1:0] ti, tj;
  logic [AW-1:0] fifo_mem [MAX_OUT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_en_q, err_q, done_q;
  logic [AW-1:0] wr_addr_q;

  logic in_mul, in_tr, segs_left, issue, pop, stray, last_pair, start_acc, mul_done;

  // FIFO depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign in_mul    = (state == S_ROW) || (state == S_COL);
  assign in_tr     = (state == S_TR1) || (state == S_TR2);
  assign segs_left = (seg != SEGS_V);
  assign issue     = mul_req && mul_ack;
  assign pop       = mul_vld && (outstanding != '0);
  assign stray     = mul_vld && (outstanding == '0);
  assign last_pair = in_tr && (ti == LAST_I) && (tj == LAST_J);
  assign start_acc = start && (state == S_IDLE);
  // True in the cycle the final write-back is on wr_en, so the next phase
  // starts on the following cycle.
  assign mul_done  = in_mul && !segs_left && (outstanding == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_ROW;
      S_ROW:   if (mul_done)  state_nxt = S_TR1;
      S_TR1:   if (last_pair) state_nxt = S_COL;
      S_COL:   if (mul_done)  state_nxt = S_TR2;
      S_TR2:   if (last_pair) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // A result returning this cycle frees a slot, so a request may issue even
  // when the in-flight count is already at MAX_OUT.
  always_comb begin
    busy      = (state != S_IDLE);
    phase     = state;
    mul_req   = in_mul && segs_left && ((outstanding < MAX_V) || mul_vld);
    mul_addr  = (in_mul && segs_left) ? AW'({seg, 3'b000}) : '0;
    sw_en     = in_tr;
    sw_addr_a = in_tr ? AW'({ti, tj}) : '0;
    sw_addr_b = in_tr ? AW'({tj, ti}) : '0;
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign err     = err_q;
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (issue) fifo_mem[wr_ptr] <= mul_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ti          <= '0;
      tj          <= LW'(1);
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_en_q <= pop;
      done_q  <= (state == S_TR2) && last_pair;

      if (pop) begin
        wr_addr_q <= fifo_mem[rd_ptr];
        rd_ptr    <= ptr_inc(rd_ptr);
      end

      if (issue) begin
        wr_ptr <= ptr_inc(wr_ptr);
        seg    <= seg + 1'b1;
      end

      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (start_acc || ((state == S_TR1) && last_pair)) seg <= '0;

      if (start_acc) err_q <= 1'b0;
      if (stray)     err_q <= 1'b1;

      // Walk the upper triangle row-major; rewind for the next transpose.
      if (in_tr) begin
        if (last_pair) begin
          ti <= '0;
          tj <= LW'(1);
        end else if (tj == LAST_J) begin
          ti <= ti + 1'b1;
          tj <= ti + LW'(2);
        end else begin
          tj <= tj + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_sequencer.sv
// tb_dct_sequencer
// Directed bench for dct_sequencer at IMG_W=16, MAX_OUT=2. A small in-bench
// multiplier model returns each issued request LAT cycles later; a monitor
// checks every issue, write-back and swap address against bench-side counters.
module tb_dct_sequencer;

  localparam int IMG_W   = 16;
  localparam int MAX_OUT = 2;
  localparam int AW      = 16;
  localparam int LAT     = 2;

  logic          clk = 1'b0;
  logic          rst, start, mul_ack, mul_vld;
  logic          busy, done, err, mul_req, wr_en, sw_en;
  logic [2:0]    phase;
  logic [AW-1:0] mul_addr, wr_addr, sw_addr_a, sw_addr_b;

  always #5 clk = ~clk;

  dct_sequencer #(.IMG_W(IMG_W), .MAX_OUT(MAX_OUT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .phase(phase), .err(err), .mul_req(mul_req), .mul_addr(mul_addr),
    .mul_ack(mul_ack), .mul_vld(mul_vld), .wr_en(wr_en), .wr_addr(wr_addr),
    .sw_en(sw_en), .sw_addr_a(sw_addr_a), .sw_addr_b(sw_addr_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit   model_on = 1'b0;
  bit   bp_on    = 1'b0;
  int   bp_left  = 0;
  bit   pipe [LAT];
  int   exp_seg = 0, exp_wseg = 0, ei = 0, ej = 1;
  int   n_issue = 0, n_wr = 0, n_sw = 0, n_done = 0;
  logic [2:0] last_phase = 3'd0;
  int   t_enter [5];
  int   last_wr_cyc = 0, last_sw_cyc = 0, row_last_wr = 0, tr1_last_sw = 0;
  int   first_sw_cyc = -1, first_col_issue = -1;
  int   phase_log [$];
  bit   saw_diag = 1'b0;
  bit   done_busy = 1'b0;
  logic [AW-1:0] last_sw_a = '0, last_sw_b = '0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive model-controlled inputs, let the cycle settle, then monitor it.
  task automatic settle();
    bit bp_act;
    bp_act = 1'b0;
    if (model_on) mul_vld = pipe[LAT-1];
    if (bp_on) begin
      bp_act  = (phase == 3'd1) && (exp_seg == 3) && (bp_left > 0);
      mul_ack = !bp_act;
    end
    #1;
    if (bp_act) begin
      check_output("bp_req_held", 32'(mul_req), 32'd1);
      check_output("bp_addr_held", 32'(mul_addr), 32'd24);
      bp_left--;
    end
    if (phase != last_phase) begin
      phase_log.push_back(int'(phase));
      if (phase <= 3'd4) t_enter[phase] = cyc;
      if (phase == 3'd1 || phase == 3'd3) begin exp_seg = 0; exp_wseg = 0; end
      if (phase == 3'd2 || phase == 3'd4) begin ei = 0; ej = 1; end
      if (phase == 3'd2) row_last_wr = last_wr_cyc;
      if (phase == 3'd3) tr1_last_sw = last_sw_cyc;
      last_phase = phase;
    end
    if (mul_req && mul_ack) begin
      check_output("issue_addr", 32'(mul_addr), 32'(exp_seg * 8));
      if (phase == 3'd3 && exp_seg == 0) first_col_issue = cyc;
      exp_seg++;
      n_issue++;
    end
    if (wr_en) begin
      check_output("wr_addr", 32'(wr_addr), 32'(exp_wseg * 8));
      exp_wseg++;
      n_wr++;
      last_wr_cyc = cyc;
    end
    if (sw_en) begin
      check_output("sw_addr_a", 32'(sw_addr_a), 32'(ei * IMG_W + ej));
      check_output("sw_addr_b", 32'(sw_addr_b), 32'(ej * IMG_W + ei));
      if (phase == 3'd2 && ei == 0 && ej == 1) first_sw_cyc = cyc;
      if (sw_addr_a == 16'h11 || sw_addr_b == 16'h11) saw_diag = 1'b1;
      last_sw_a = sw_addr_a;
      last_sw_b = sw_addr_b;
      if (ej == IMG_W - 1) begin ei++; ej = ei + 1; end
      else ej++;
      n_sw++;
      last_sw_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_busy = busy;
      check_output("done_excl", 32'({wr_en, sw_en}), 32'd0);
    end
  endtask

  // Shift the multiplier model, then move to just after the next edge.
  task automatic advance();
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] = 1'b0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = model_on && mul_req && mul_ack;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_output({pfx, "_busy"},   32'(busy),      32'd0);
    check_output({pfx, "_done"},   32'(done),      32'd0);
    check_output({pfx, "_phase"},  32'(phase),     32'd0);
    check_output({pfx, "_err"},    32'(err),       32'd0);
    check_output({pfx, "_req"},    32'(mul_req),   32'd0);
    check_output({pfx, "_maddr"},  32'(mul_addr),  32'd0);
    check_output({pfx, "_wr_en"},  32'(wr_en),     32'd0);
    check_output({pfx, "_wraddr"}, 32'(wr_addr),   32'd0);
    check_output({pfx, "_sw_en"},  32'(sw_en),     32'd0);
    check_output({pfx, "_swa"},    32'(sw_addr_a), 32'd0);
    check_output({pfx, "_swb"},    32'(sw_addr_b), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_ph [5] = '{1, 2, 3, 4, 0};
    int sw_base;

    for (int k = 0; k < LAT; k++) pipe[k] = 1'b0;
    rst = 1'b1; start = 1'b0; mul_ack = 1'b0; mul_vld = 1'b0;
    @(posedge clk); #1;
    tick();
    settle();
    check_reset_outputs("reset");
    advance();
    rst = 1'b0;

    // Unsolicited result while idle: flags err, produces no write-back.
    mul_vld = 1'b1;
    tick();
    mul_vld = 1'b0;
    settle();
    check_output("stray_err", 32'(err), 32'd1);
    check_output("stray_wr_en", 32'(wr_en), 32'd0);
    advance();

    // Full transform, ack always high, latency LAT.
    model_on = 1'b1;
    mul_ack  = 1'b1;
    phase_log.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    check_output("first_phase", 32'(phase), 32'd1);
    check_output("first_busy", 32'(busy), 32'd1);
    check_output("first_req", 32'(mul_req), 32'd1);
    check_output("first_addr", 32'(mul_addr), 32'd0);
    check_output("err_cleared", 32'(err), 32'd0);
    advance();
    for (int g = 0; g < 1000 && n_done == 0; g++) tick();
    for (int g = 0; g < 3; g++) tick();
    check_output("done_count", 32'(n_done), 32'd1);
    check_output("done_busy", 32'(done_busy), 32'd0);
    check_output("issue_count", 32'(n_issue), 32'd64);
    check_output("wr_count", 32'(n_wr), 32'd64);
    check_output("sw_count", 32'(n_sw), 32'd240);
    check_output("run1_err", 32'(err), 32'd0);
    check_output("row_span", 32'(t_enter[2] - t_enter[1]), 32'd35);
    check_output("tr1_after_wr", 32'(t_enter[2] - row_last_wr), 32'd1);
    check_output("first_sw_cyc", 32'(first_sw_cyc), 32'(t_enter[2]));
    check_output("tr1_span", 32'(t_enter[3] - t_enter[2]), 32'd120);
    check_output("col_after_sw", 32'(t_enter[3] - tr1_last_sw), 32'd1);
    check_output("first_col_issue", 32'(first_col_issue), 32'(t_enter[3]));
    check_output("last_pair_a", 32'(last_sw_a), 32'd239);
    check_output("last_pair_b", 32'(last_sw_b), 32'd254);
    check_output("diag_untouched", 32'(saw_diag), 32'd0);
    check_output("phase_log_len", 32'(phase_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < phase_log.size(); k++)
      check_output("phase_seq", 32'(phase_log[k]), 32'(exp_ph[k]));

    // Second transform: backpressure at segment 3, start while busy, then
    // withheld results and a reset in the column pass.
    sw_base = n_sw;
    bp_on   = 1'b1;
    bp_left = 5;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 500 && phase != 3'd2; g++) tick();
    check_output("row2_reached_tr1", 32'(phase), 32'd2);
    check_output("bp_exercised", 32'(bp_left), 32'd0);
    bp_on   = 1'b0;
    mul_ack = 1'b1;
    for (int g = 0; g < 10; g++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    check_output("busy_start_phase", 32'(phase), 32'd2);
    check_output("busy_start_busy", 32'(busy), 32'd1);
    advance();
    for (int g = 0; g < 300 && phase != 3'd3; g++) tick();
    check_output("tr1_reached_col", 32'(phase), 32'd3);
    check_output("tr1_swaps", 32'(n_sw - sw_base), 32'd120);

    model_on = 1'b0;
    mul_vld  = 1'b0;
    tick();
    tick();
    settle();
    check_output("full_req_low_a", 32'(mul_req), 32'd0);
    advance();
    settle();
    check_output("full_req_low_b", 32'(mul_req), 32'd0);
    advance();
    mul_vld = 1'b1;
    settle();
    check_output("vld_req", 32'(mul_req), 32'd1);
    check_output("vld_req_addr", 32'(mul_addr), 32'd16);
    advance();
    mul_vld = 1'b0;
    settle();
    check_output("still_full_req", 32'(mul_req), 32'd0);
    check_output("col_wr_en", 32'(wr_en), 32'd1);
    check_output("col_wr_addr", 32'(wr_addr), 32'd0);
    advance();
    mul_vld = 1'b1;
    tick();
    mul_vld = 1'b0;
    rst = 1'b1;
    settle();
    check_output("pre_rst_wr_addr", 32'(wr_addr), 32'd8);
    advance();
    rst = 1'b0;
    settle();
    check_reset_outputs("midrst");
    advance();
    mul_vld = 1'b1;
    tick();
    mul_vld = 1'b0;
    settle();
    check_output("post_rst_err", 32'(err), 32'd1);
    check_output("post_rst_wr_en", 32'(wr_en), 32'd0);
    check_output("post_rst_phase", 32'(phase), 32'd0);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
